// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding request, IDLE/FETCH/VALID sequencing,
// branch/jump redirects on consume, and flush with kill of an in-flight response.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Branch,
    input  logic        Jal,
    input  logic        Jalr,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JalTarget,
    input  logic [31:0] JalrTarget,
    input  logic        Flush,
    input  logic [31:0] FlushTarget,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic        Error
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] kill_pc;
    logic        kill;

    logic        multi_redir;
    logic        any_redir;
    logic [31:0] sel_target;
    logic [31:0] next_pc;
    logic        next_err;
    logic [31:0] flush_pc;
    logic        flush_err;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic misaligned(input logic [31:0] a);
        return (a[1:0] != 2'b00);
    endfunction

    // Next fetch address at the consume edge; conflicting redirects fall through to PC+4.
    always_comb begin
        multi_redir = (Branch & Jal) | (Branch & Jalr) | (Jal & Jalr);
        any_redir   = Branch | Jal | Jalr;
        sel_target  = JalrTarget;
        if (Jal)
            sel_target = JalTarget;
        if (Branch)
            sel_target = BranchTarget;
        if (any_redir && !multi_redir) begin
            next_pc  = align_word(sel_target);
            next_err = misaligned(sel_target);
        end else begin
            next_pc  = PC + 32'd4;
            next_err = multi_redir;
        end
    end

    assign flush_pc  = align_word(FlushTarget);
    assign flush_err = misaligned(FlushTarget);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            PC         <= RESET_PC;
            fetch_pc   <= RESET_PC;
            Instr      <= 32'h0;
            InstrValid <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            Error      <= 1'b0;
            kill       <= 1'b0;
            kill_pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (Flush) begin
                        fetch_pc  <= flush_pc;
                        imem_addr <= flush_pc;
                        if (flush_err)
                            Error <= 1'b1;
                    end else begin
                        imem_addr <= fetch_pc;
                    end
                end
                FETCH: begin
                    if (flush_err && Flush)
                        Error <= 1'b1;
                    if (imem_ack) begin
                        // A killed response is dropped and the request reissued to the flush target.
                        if (Flush || kill) begin
                            kill      <= 1'b0;
                            fetch_pc  <= Flush ? flush_pc : kill_pc;
                            imem_addr <= Flush ? flush_pc : kill_pc;
                        end else begin
                            Instr      <= imem_rdata;
                            PC         <= fetch_pc;
                            InstrValid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= VALID;
                        end
                    end else if (Flush) begin
                        kill    <= 1'b1;
                        kill_pc <= flush_pc;
                    end
                end
                VALID: begin
                    if (Flush) begin
                        InstrValid <= 1'b0;
                        fetch_pc   <= flush_pc;
                        imem_addr  <= flush_pc;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                        if (flush_err)
                            Error <= 1'b1;
                    end else if (!Stall) begin
                        InstrValid <= 1'b0;
                        fetch_pc   <= next_pc;
                        imem_addr  <= next_pc;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                        if (next_err)
                            Error <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller: a behavioural memory drives acks with random wait
// states, and an event-level reference model predicts every visible output each cycle.
module tb_fetch_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int NCYC = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        Branch, Jal, Jalr;
    logic [31:0] BranchTarget, JalTarget, JalrTarget;
    logic        Flush;
    logic [31:0] FlushTarget;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC, Instr;
    logic        InstrValid, Error;

    fetch_controller #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .Branch(Branch), .Jal(Jal), .Jalr(Jalr),
        .BranchTarget(BranchTarget), .JalTarget(JalTarget), .JalrTarget(JalrTarget),
        .Flush(Flush), .FlushTarget(FlushTarget), .Stall(Stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PC(PC), .Instr(Instr), .InstrValid(InstrValid), .Error(Error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: "busy" means a request is outstanding, "have" means an instruction is presented.
    bit          m_started;   // false only during the single post-reset idle cycle
    bit          m_busy, m_have, m_err, m_kill;
    logic [31:0] m_next, m_pc, m_instr, m_addr, m_kill_to;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a - (a % 4);
    endfunction

    task automatic go_to(input logic [31:0] t);
        if (t % 4 != 0) m_err = 1;
        m_next  = word_of(t);
        m_addr  = m_next;
        m_busy  = 1;
        m_have  = 0;
    endtask

    task automatic model_step();
        int nred;
        logic [31:0] tgt;
        if (!rst) begin
            m_started = 0; m_busy = 0; m_have = 0; m_err = 0; m_kill = 0;
            m_next = RST_PC; m_pc = RST_PC; m_instr = 0; m_addr = RST_PC;
            return;
        end
        if (!m_started) begin
            m_started = 1;
            go_to(Flush ? FlushTarget : m_next);
        end else if (m_busy) begin
            if (imem_ack && (Flush || m_kill)) begin
                m_kill = 0;
                go_to(Flush ? FlushTarget : m_kill_to);
            end else if (imem_ack) begin
                m_instr = imem_rdata; m_pc = m_next; m_have = 1; m_busy = 0;
            end else if (Flush) begin
                if (FlushTarget % 4 != 0) m_err = 1;
                m_kill = 1; m_kill_to = FlushTarget;
            end
        end else if (m_have) begin
            if (Flush) go_to(FlushTarget);
            else if (!Stall) begin
                nred = int'(Branch) + int'(Jal) + int'(Jalr);
                if (nred == 1) begin
                    tgt = Branch ? BranchTarget : (Jal ? JalTarget : JalrTarget);
                    go_to(tgt);
                end else begin
                    go_to(m_pc + 32'd4);
                    if (nred > 1) m_err = 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 6))
            0: return 32'hFFFF_FFFC;
            1: return 32'h0000_0033;
            2: return 32'h0000_0040;
            3: return 32'h0000_0100;
            4: return $urandom;
            default: return {$urandom_range(0, 255), 2'b00};
        endcase
    endfunction

    logic [31:0] quiet_addrs[$];
    int wcnt;
    int rst_hold;
    bit quiet;
    logic [31:0] exp_seq[4];

    initial begin
        rst = 0; Branch = 0; Jal = 0; Jalr = 0; Flush = 0; Stall = 0;
        BranchTarget = 0; JalTarget = 0; JalrTarget = 0; FlushTarget = 0;
        imem_ack = 0; imem_rdata = 0;
        wcnt = -1; rst_hold = 0;
        exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc >= 1) begin
                check_val("imem_req",   imem_req,   m_busy);
                check_val("imem_addr",  imem_addr,  m_addr);
                check_val("InstrValid", InstrValid, m_have);
                check_val("PC",         PC,         m_pc);
                check_val("Instr",      Instr,      m_instr);
                check_val("Error",      Error,      m_err);
            end
            quiet = (cyc < 24);
            if (quiet && cyc >= 3 && imem_req) quiet_addrs.push_back(imem_addr);
            if (cyc == 24) begin
                check_val("first_seq_len", quiet_addrs.size() >= 4, 1);
                for (int i = 0; i < 4 && i < quiet_addrs.size(); i++)
                    check_val("first_seq", quiet_addrs[i], exp_seq[i]);
            end

            // Reset: held for the first cycles, then occasional pulses.
            if (cyc < 3) rst = 0;
            else if (rst_hold > 0) begin rst = 0; rst_hold--; end
            else if (!quiet && $urandom_range(0, 299) == 0) begin
                rst = 0; rst_hold = $urandom_range(0, 2);
            end else rst = 1;

            Branch = 0; Jal = 0; Jalr = 0; Flush = 0; Stall = 0;
            if (!quiet) begin
                Branch = ($urandom_range(0, 5) == 0);
                Jal    = ($urandom_range(0, 5) == 0);
                Jalr   = ($urandom_range(0, 5) == 0);
                Flush  = ($urandom_range(0, 19) == 0);
                Stall  = ($urandom_range(0, 2) == 0);
            end
            BranchTarget = pick_target();
            JalTarget    = pick_target();
            JalrTarget   = pick_target();
            FlushTarget  = pick_target();

            // Memory: random wait states per request; stray acks while idle.
            imem_rdata = $urandom;
            if (imem_req) begin
                if (wcnt < 0) wcnt = quiet ? 0 : $urandom_range(0, 3);
                if (wcnt == 0) begin imem_ack = 1; wcnt = -1; end
                else begin imem_ack = 0; wcnt--; end
            end else begin
                wcnt = -1;
                imem_ack = !quiet && ($urandom_range(0, 5) == 0);
            end

            @(posedge clk);
            model_step();
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
